// File: rtl/bullet_collision.sv
// Bullet collision checker: samples the live bullet position, tests it against the
// screen bounds, the enemy tank box and the tile map, then reports the impact.
module bullet_collision #(
    parameter int SCREEN_W    = 640,
    parameter int SCREEN_H    = 480,
    parameter int TANK_SIZE   = 32,
    parameter int EXPL_CYCLES = 2500000,
    parameter int MAP_COLS    = 40
) (
    input  logic        i_clk25,
    input  logic        i_reset_n,
    input  logic        i_bullet_act,
    input  logic [9:0]  i_bullet_x,
    input  logic [8:0]  i_bullet_y,
    input  logic [9:0]  i_enemy_x,
    input  logic [8:0]  i_enemy_y,
    output logic [10:0] o_map_addr,
    input  logic [1:0]  i_map_data,
    output logic        o_wall_we,
    output logic [10:0] o_wall_addr,
    output logic        o_des_bullet,
    output logic        o_hit_tank,
    output logic        o_explosion_flag,
    output logic [9:0]  o_expl_x,
    output logic [8:0]  o_expl_y
);

    localparam int               CNT_W    = (EXPL_CYCLES > 1) ? $clog2(EXPL_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(EXPL_CYCLES - 1);
    localparam logic [9:0]       SCR_W    = 10'(SCREEN_W);
    localparam logic [8:0]       SCR_H    = 9'(SCREEN_H);
    localparam logic [1:0]       TILE_BRICK = 2'd1;
    localparam logic [1:0]       TILE_STEEL = 2'd2;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SAMPLE,
        S_WAIT,
        S_EVAL,
        S_HIT,
        S_EXPLODE
    } state_t;

    state_t           r_state;
    logic [9:0]       r_sx;
    logic [8:0]       r_sy;
    logic             r_expl_pending;
    logic [CNT_W-1:0] r_cnt;

    logic [10:0] w_sample_addr;
    logic [10:0] w_ex_max;
    logic [9:0]  w_ey_max;
    logic        w_oob;
    logic        w_tank;

    // Product and sums are widened so neither the address nor the box edges wrap.
    assign w_sample_addr = 11'(i_bullet_y[8:4]) * 11'(MAP_COLS) + 11'(i_bullet_x[9:4]);
    assign w_ex_max      = {1'b0, i_enemy_x} + 11'(TANK_SIZE - 1);
    assign w_ey_max      = {1'b0, i_enemy_y} + 10'(TANK_SIZE - 1);
    assign w_oob         = (r_sx >= SCR_W) || (r_sy >= SCR_H);
    assign w_tank        = (r_sx >= i_enemy_x) && ({1'b0, r_sx} <= w_ex_max) &&
                           (r_sy >= i_enemy_y) && ({1'b0, r_sy} <= w_ey_max);

    always_ff @(posedge i_clk25 or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_state          <= S_IDLE;
            r_sx             <= '0;
            r_sy             <= '0;
            r_expl_pending   <= 1'b0;
            r_cnt            <= '0;
            o_map_addr       <= '0;
            o_wall_we        <= 1'b0;
            o_wall_addr      <= '0;
            o_des_bullet     <= 1'b0;
            o_hit_tank       <= 1'b0;
            o_explosion_flag <= 1'b0;
            o_expl_x         <= '0;
            o_expl_y         <= '0;
        end else begin
            o_des_bullet <= 1'b0;
            o_hit_tank   <= 1'b0;
            o_wall_we    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (i_bullet_act) r_state <= S_SAMPLE;
                end
                S_SAMPLE: begin
                    if (!i_bullet_act) begin
                        r_state <= S_IDLE;
                    end else begin
                        r_sx       <= i_bullet_x;
                        r_sy       <= i_bullet_y;
                        o_map_addr <= w_sample_addr;
                        r_state    <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_state <= i_bullet_act ? S_EVAL : S_IDLE;
                end
                S_EVAL: begin
                    if (!i_bullet_act) begin
                        r_state <= S_IDLE;
                    end else if (w_oob) begin
                        o_des_bullet   <= 1'b1;
                        r_expl_pending <= 1'b0;
                        r_state        <= S_HIT;
                    end else if (w_tank || i_map_data == TILE_BRICK || i_map_data == TILE_STEEL) begin
                        o_des_bullet   <= 1'b1;
                        o_hit_tank     <= w_tank;
                        // Tank takes priority, so a brick under the tank is left intact.
                        o_wall_we      <= !w_tank && (i_map_data == TILE_BRICK);
                        if (!w_tank && i_map_data == TILE_BRICK) o_wall_addr <= o_map_addr;
                        o_expl_x       <= r_sx;
                        o_expl_y       <= r_sy;
                        r_expl_pending <= 1'b1;
                        r_state        <= S_HIT;
                    end else begin
                        r_state <= S_SAMPLE;
                    end
                end
                S_HIT: begin
                    if (r_expl_pending) begin
                        o_explosion_flag <= 1'b1;
                        r_cnt            <= '0;
                        r_state          <= S_EXPLODE;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_EXPLODE: begin
                    if (r_cnt == CNT_LAST) begin
                        o_explosion_flag <= 1'b0;
                        r_cnt            <= '0;
                        r_state          <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule
